// File: rtl/arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package arb_pkg;

    localparam int unsigned NREQ_MAX = 8;
    localparam int unsigned IDXW     = $clog2(NREQ_MAX);
    localparam int unsigned AW_DEF   = 32;
    localparam int unsigned DW_DEF   = 32;
    localparam int unsigned AW_MAX   = 64;
    localparam int unsigned DW_MAX   = 64;

    // Sized for the widest supported port; the top uses the low AW/DW bits.
    typedef struct packed {
        logic [AW_MAX-1:0]   addr;
        logic [DW_MAX-1:0]   wdata;
        logic [DW_MAX/8-1:0] be;
        logic                write;
    } mem_cmd_t;

    typedef struct packed {
        logic            valid;
        logic            read;
        logic [IDXW-1:0] idx;
    } tag_t;

    function automatic logic [IDXW-1:0] next_ptr(input logic [IDXW-1:0] idx,
                                                 input int unsigned nreq);
        return (idx == IDXW'(nreq - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: first set request at or above ptr, wrapping.
module rr_picker
    import arb_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] idx,
    output logic            found
);

    int unsigned cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(ptr) + k) % NREQ;
            if (!found && req[cand]) begin
                found     = 1'b1;
                idx       = IDXW'(cand);
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port, with read-response routing.
// Optional grant locking is enabled by defining ARB_LOCK_EN.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned DW   = DW_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_write,
    input  logic [NREQ*AW-1:0]     req_addr,
    input  logic [NREQ*DW-1:0]     req_wdata,
    input  logic [NREQ*(DW/8)-1:0] req_be,
    input  logic [NREQ-1:0]        req_lock,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DW-1:0]          rsp_rdata,
    output logic [AW-1:0]          memaddr,
    output logic                   memwrite,
    output logic                   memread,
    output logic [DW-1:0]          writedata,
    output logic [DW/8-1:0]        be,
    input  logic [DW-1:0]          readdata
);

    localparam int unsigned BW = DW / 8;

    if (NREQ < 2 || NREQ > NREQ_MAX || AW > AW_MAX || DW > DW_MAX || DW % 8 != 0) begin : g_chk
        $error("mem_port_arbiter: unsupported parameter combination");
    end

    logic [IDXW-1:0] ptr_q, ptr_d;
    mem_cmd_t        cmd_q, cmd_d;
    tag_t            tag0_q, tag0_d, tag1_q;

    logic [NREQ-1:0] pick_gnt;
    logic [IDXW-1:0] pick_idx;
    logic            pick_found;
    logic            locked;
    logic            win;
    logic [IDXW-1:0] win_idx;

    rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .req   (req_valid),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

`ifdef ARB_LOCK_EN
    logic [IDXW-1:0] last_q;
    logic            last_vld_q;

    assign locked = last_vld_q && req_valid[last_q] && req_lock[last_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else if (win) begin
            last_q     <= win_idx;
            last_vld_q <= 1'b1;
        end
    end

    assign win_idx = locked ? last_q : pick_idx;
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign locked      = 1'b0;
    assign win_idx     = pick_idx;
`endif

    // No grants while reset is held, so nothing is accepted that would be dropped.
    assign win = !reset && (locked || pick_found);

    always_comb begin
        gnt    = '0;
        cmd_d  = cmd_q;
        tag0_d = '0;
        ptr_d  = ptr_q;
        if (win) begin
            gnt[win_idx] = 1'b1;
            cmd_d.addr   = AW_MAX'(req_addr[win_idx*AW +: AW]);
            cmd_d.wdata  = DW_MAX'(req_wdata[win_idx*DW +: DW]);
            cmd_d.be     = (DW_MAX/8)'(req_be[win_idx*BW +: BW]);
            cmd_d.write  = req_write[win_idx];
            tag0_d.valid = 1'b1;
            tag0_d.read  = !req_write[win_idx];
            tag0_d.idx   = win_idx;
            if (!locked) begin
                ptr_d = next_ptr(win_idx, NREQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= '0;
            cmd_q  <= '0;
            tag0_q <= '0;
            tag1_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            cmd_q  <= cmd_d;
            tag0_q <= tag0_d;
            tag1_q <= tag0_q;
        end
    end

    assign memaddr   = cmd_q.addr[AW-1:0];
    assign writedata = cmd_q.wdata[DW-1:0];
    assign be        = cmd_q.be[BW-1:0];
    assign memread   = tag0_q.valid && tag0_q.read;
    assign memwrite  = tag0_q.valid && cmd_q.write;

    logic unused_cmd;
    assign unused_cmd = ^cmd_q;

    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (tag1_q.valid && tag1_q.read) begin
            rsp_valid[tag1_q.idx] = 1'b1;
            rsp_rdata             = readdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter with NREQ=2 and a simple memory model.
module tb_mem_port_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;

    localparam logic [31:0] A0   = 32'h10;
    localparam logic [31:0] A1   = 32'h40;
    localparam logic [31:0] D0   = 32'h55;
    localparam logic [31:0] D1   = 32'hA0A0_A0A0;
    localparam logic [3:0]  B0   = 4'b0001;
    localparam logic [3:0]  B1   = 4'b1111;
    localparam logic [31:0] M10  = 32'h1111_1111;
    localparam logic [31:0] M40  = 32'hDEAD_BEEF;
    localparam logic [31:0] M10W = 32'h1111_1155;

    logic              clk;
    logic              reset;
    logic [1:0]        req_valid;
    logic [1:0]        req_write;
    logic [2*AW-1:0]   req_addr;
    logic [2*DW-1:0]   req_wdata;
    logic [7:0]        req_be;
    logic [1:0]        req_lock;
    logic [1:0]        gnt;
    logic [1:0]        rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic [AW-1:0]     memaddr;
    logic              memwrite;
    logic              memread;
    logic [DW-1:0]     writedata;
    logic [3:0]        be;
    logic [DW-1:0]     readdata;

    mem_port_arbiter #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .req_lock  (req_lock),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .memaddr   (memaddr),
        .memwrite  (memwrite),
        .memread   (memread),
        .writedata (writedata),
        .be        (be),
        .readdata  (readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed memory with byte enables and 1-cycle read latency.
    logic [31:0] mem [0:63];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[A0[7:2]] = M10;
        mem[A1[7:2]] = M40;
        readdata     = 32'h0;
    end
    always @(posedge clk) begin
        if (memwrite) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[memaddr[7:2]][b*8 +: 8] <= writedata[b*8 +: 8];
        end
        if (memread) readdata <= mem[memaddr[7:2]];
    end

    typedef struct {
        logic        rst;
        logic [1:0]  v, w, lk;
        logic [1:0]  egnt;
        logic        erd, ewr;
        logic [1:0]  ersp;
        logic [31:0] erdata;
        logic [1:0]  chk;      // 0: no bus check, 1: memaddr, 2: memaddr+writedata+be
        logic [31:0] eaddr, ewdata;
        logic [3:0]  ebe;
    } row_t;

    row_t rows[$];
    int   n_err = 0;
    int   n_chk = 0;

    function automatic row_t r(input logic rst, input logic [1:0] v, input logic [1:0] w,
                               input logic [1:0] lk, input logic [1:0] egnt, input logic erd,
                               input logic ewr, input logic [1:0] ersp, input logic [31:0] erdata,
                               input logic [1:0] chk, input logic [31:0] eaddr,
                               input logic [31:0] ewdata, input logic [3:0] ebe);
        row_t x;
        x.rst = rst; x.v = v; x.w = w; x.lk = lk; x.egnt = egnt; x.erd = erd; x.ewr = ewr;
        x.ersp = ersp; x.erdata = erdata; x.chk = chk; x.eaddr = eaddr; x.ewdata = ewdata;
        x.ebe = ebe;
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [1:0] v, input logic [1:0] w,
                         input logic [1:0] lk);
        reset     = rst;
        req_valid = v;
        req_write = w;
        req_lock  = lk;
    endtask

    logic [1:0] lg1;
    int         seen;
    int         gcnt0, gcnt1, issues, bad_onehot;

    initial begin
        req_addr  = {A1, A0};
        req_wdata = {D1, D0};
        req_be    = {B1, B0};
        drive(1'b1, 2'b11, 2'b00, 2'b00);

`ifdef ARB_LOCK_EN
        lg1 = 2'b01;
`else
        lg1 = 2'b10;
`endif
        // rst  v      w      lk     gnt    rd wr rsp    rdata chk  addr  wdata  be
        rows.push_back(r(1, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0,    2, 0,  0,  0));
        rows.push_back(r(0, 2'b11, 2'b00, 2'b00, 2'b01, 0, 0, 2'b00, 0,    0, 0,  0,  0));
        rows.push_back(r(0, 2'b10, 2'b00, 2'b00, 2'b10, 1, 0, 2'b00, 0,    1, A0, 0,  0));
        rows.push_back(r(0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 2'b01, M10,  1, A1, 0,  0));
        rows.push_back(r(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b10, M40,  0, 0,  0,  0));
        rows.push_back(r(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0,    0, 0,  0,  0));
        rows.push_back(r(0, 2'b11, 2'b00, 2'b00, 2'b01, 0, 0, 2'b00, 0,    0, 0,  0,  0));
        rows.push_back(r(0, 2'b11, 2'b00, 2'b00, 2'b10, 1, 0, 2'b00, 0,    1, A0, 0,  0));
        rows.push_back(r(0, 2'b11, 2'b00, 2'b00, 2'b01, 1, 0, 2'b01, M10,  1, A1, 0,  0));
        rows.push_back(r(0, 2'b11, 2'b00, 2'b00, 2'b10, 1, 0, 2'b10, M40,  1, A0, 0,  0));
        rows.push_back(r(0, 2'b11, 2'b00, 2'b00, 2'b01, 1, 0, 2'b01, M10,  1, A1, 0,  0));
        rows.push_back(r(0, 2'b11, 2'b00, 2'b00, 2'b10, 1, 0, 2'b10, M40,  1, A0, 0,  0));
        rows.push_back(r(0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 2'b01, M10,  1, A1, 0,  0));
        rows.push_back(r(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b10, M40,  0, 0,  0,  0));
        rows.push_back(r(0, 2'b11, 2'b01, 2'b00, 2'b01, 0, 0, 2'b00, 0,    0, 0,  0,  0));
        rows.push_back(r(0, 2'b10, 2'b00, 2'b00, 2'b10, 0, 1, 2'b00, 0,    2, A0, D0, B0));
        rows.push_back(r(0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 0,    1, A1, 0,  0));
        rows.push_back(r(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b10, M40,  0, 0,  0,  0));
        rows.push_back(r(0, 2'b01, 2'b00, 2'b00, 2'b01, 0, 0, 2'b00, 0,    0, 0,  0,  0));
        rows.push_back(r(0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 0,    1, A0, 0,  0));
        rows.push_back(r(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b01, M10W, 0, 0,  0,  0));
        // Wrap: rr_ptr is 1 here and only req 0 is valid.
        rows.push_back(r(0, 2'b01, 2'b00, 2'b00, 2'b01, 0, 0, 2'b00, 0,    0, 0,  0,  0));
        rows.push_back(r(0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 0,    1, A0, 0,  0));
        rows.push_back(r(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b01, M10W, 0, 0,  0,  0));
        // Lock held by req 0 for three writes while req 1 waits.
        rows.push_back(r(0, 2'b01, 2'b11, 2'b01, 2'b01, 0, 0, 2'b00, 0,    0, 0,  0,  0));
        rows.push_back(r(0, 2'b11, 2'b11, 2'b01, lg1,   0, 1, 2'b00, 0,    2, A0, D0, B0));
        rows.push_back(r(0, 2'b11, 2'b11, 2'b01, 2'b01, 0, 1, 2'b00, 0,    0, 0,  0,  0));
        rows.push_back(r(0, 2'b11, 2'b11, 2'b00, 2'b10, 0, 1, 2'b00, 0,    0, 0,  0,  0));
        rows.push_back(r(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 2'b00, 0,    2, A1, D1, B1));
        // Reset in the command cycle of a read drops its response and clears rr_ptr.
        rows.push_back(r(0, 2'b01, 2'b00, 2'b00, 2'b01, 0, 0, 2'b00, 0,    0, 0,  0,  0));
        rows.push_back(r(1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 0,    1, A0, 0,  0));
        rows.push_back(r(0, 2'b11, 2'b00, 2'b00, 2'b01, 0, 0, 2'b00, 0,    0, 0,  0,  0));
        rows.push_back(r(0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 0,    1, A0, 0,  0));
        rows.push_back(r(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b01, M10W, 0, 0,  0,  0));

        foreach (rows[i]) begin
            @(posedge clk);
            #1;
            drive(rows[i].rst, rows[i].v, rows[i].w, rows[i].lk);
            @(negedge clk);
            check($sformatf("r%0d_gnt", i), 64'(gnt), 64'(rows[i].egnt));
            check($sformatf("r%0d_memread", i), 64'(memread), 64'(rows[i].erd));
            check($sformatf("r%0d_memwrite", i), 64'(memwrite), 64'(rows[i].ewr));
            check($sformatf("r%0d_rsp_valid", i), 64'(rsp_valid), 64'(rows[i].ersp));
            if (rows[i].ersp != 2'b00 || rows[i].rst)
                check($sformatf("r%0d_rsp_rdata", i), 64'(rsp_rdata), 64'(rows[i].erdata));
            if (rows[i].chk != 2'd0)
                check($sformatf("r%0d_memaddr", i), 64'(memaddr), 64'(rows[i].eaddr));
            if (rows[i].chk == 2'd2) begin
                check($sformatf("r%0d_writedata", i), 64'(writedata), 64'(rows[i].ewdata));
                check($sformatf("r%0d_be", i), 64'(be), 64'(rows[i].ebe));
            end
        end

        // Read latency: req 1 reads 0x40 (last written with D1); response expected 2 cycles on.
        @(posedge clk);
        #1;
        drive(1'b0, 2'b10, 2'b00, 2'b00);
        @(negedge clk);
        check("lat_gnt", 64'(gnt), 64'(2'b10));
        @(posedge clk);
        #1;
        drive(1'b0, 2'b00, 2'b00, 2'b00);
        seen = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) begin
                seen = k;
                break;
            end
        end
        if (seen == 0) begin
            check("lat_rsp_timeout", 64'(rsp_valid), 64'(2'b10));
        end else begin
            check("lat_cycles", 64'(seen), 64'd2);
            check("lat_rsp_valid", 64'(rsp_valid), 64'(2'b10));
            check("lat_rsp_rdata", 64'(rsp_rdata), 64'(D1));
        end

        // Throughput: both valid for 8 cycles, every cycle after the first must issue.
        gcnt0 = 0; gcnt1 = 0; issues = 0; bad_onehot = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            drive(1'b0, 2'b11, 2'b00, 2'b00);
            @(negedge clk);
            if (gnt[0]) gcnt0++;
            if (gnt[1]) gcnt1++;
            if ($countones(gnt) != 1) bad_onehot++;
            if (k > 0 && (memread || memwrite)) issues++;
        end
        check("tput_gnt0", 64'(gcnt0), 64'd4);
        check("tput_gnt1", 64'(gcnt1), 64'd4);
        check("tput_onehot", 64'(bad_onehot), 64'd0);
        check("tput_issues", 64'(issues), 64'd7);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            drive(1'b0, 2'b00, 2'b00, 2'b00);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single data-memory port (memaddr/memwrite/memread/writedata/be/readdata) between NREQ requesters, such as the core's load/store path, a DMA engine and a debug master. It uses round-robin arbitration with a one-transaction-per-cycle pipelined command stage and response routing for reads. It sits between the requesters and the data memory, which has a synchronous read with 1-cycle latency.

## Interface
Parameters:
- NREQ, 2: number of requesters (2..8).
- AW, 32: address width.
- DW, 32: data width; byte enables are DW/8 wide.

Ports:
- clk  in  1: single clock, rising edge.
- reset  in  1: synchronous, active-high.
- req_valid  in  NREQ: requester i has a pending access.
- req_write  in  NREQ: 1 = store, 0 = load.
- req_addr  in  NREQ*AW: packed, requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW: packed store data.
- req_be  in  NREQ*(DW/8): packed byte enables.
- req_lock  in  NREQ: hold grant across consecutive accesses (ARB_LOCK_EN only; ignored otherwise).
- gnt  out  NREQ: one-hot accept pulse; requester presents its next access in the following cycle.
- rsp_valid  out  NREQ: one-hot, read data for requester i is on rsp_rdata.
- rsp_rdata  out  DW: read data, shared by all requesters.
- memaddr  out  AW, memwrite  out  1, memread  out  1, writedata  out  DW, be  out  DW/8: memory command, all registered.
- readdata  in  DW: memory read data, valid 1 cycle after memread.

## Operation
- **Arbitration (cycle N):** the winner is the first requester with req_valid set, searching from rr_ptr upward with wrap at NREQ-1 to 0. gnt[winner] is high in cycle N and is combinational from req_valid and rr_ptr. At most one gnt bit is set.
- **Command stage:** the winner's addr, wdata, be and write are registered. In cycle N+1, memread = !write and memwrite = write, each high for exactly one cycle per grant. When no grant occurs, memread = memwrite = 0. memaddr, writedata and be hold their last values.
- **Pointer update:** after a grant to i, rr_ptr = (i+1) mod NREQ. With no grant, rr_ptr is unchanged.
- **Read return:** a 2-deep tag pipeline tracks the winner index and the read flag. In cycle N+2, rsp_valid[i] = 1 and rsp_rdata = readdata. Writes produce no response.
- **Ordering and rate:** responses return in issue order. One access is issued per cycle, so back-to-back grants are allowed and reach full throughput with no bubbles.
- **Ignored requests:** a requester that drops req_valid before it receives gnt is not serviced. No state is kept for it.

## Timing
- **Reset values:** gnt = 0, rsp_valid = 0, rsp_rdata = 0, memread = 0, memwrite = 0, memaddr = 0, writedata = 0, be = 0, rr_ptr = 0, tag pipeline cleared.
- **Reset mid-operation:** in-flight reads are dropped and no rsp_valid is issued afterward. A write already on the memory bus in the reset cycle completes at memory, but the arbiter does not track it.
- **Latency:**
  - Grant is issued in the request cycle when the port is free.
  - The memory command appears at +1.
  - Read response arrives at +2.
- **Simultaneous requests:** with all NREQ requesters valid, each is granted exactly once per NREQ cycles.
- **Wrap:** with rr_ptr = NREQ-1 and only req 0 valid, req 0 is granted that same cycle.

## Configuration
- **ARB_LOCK_EN defined:** if the last winner i has req_lock[i]=1 and req_valid[i]=1, i wins again regardless of rr_ptr, and rr_ptr is not advanced. The lock releases on the first cycle that req_lock[i]=0 or req_valid[i]=0, and normal round-robin then resumes from i+1.
- **ARB_LOCK_EN undefined:** the req_lock port is present but ignored. Pure round-robin applies.

## Structure
- **Package arb_pkg:**
  - NREQ_MAX = 8.
  - Default AW and DW.
  - A mem_cmd_t struct with addr, wdata, be and write.
  - A tag_t struct with valid, read and idx[$clog2(NREQ_MAX)-1:0].
- **Sub-module rr_picker:** combinational round-robin priority encoder. Inputs are the request vector and rr_ptr; outputs are the one-hot grant and the encoded index.
- **Top level:** holds the command registers, rr_ptr, the tag pipeline and the lock logic.

## Test plan
- **Reset:** assert reset for 2 cycles with all req_valid=1 → all outputs 0, and no gnt during reset. The first gnt after release goes to req 0.
- **Single read:** req 1 reads addr 0x40, memory returns 0xDEADBEEF → gnt[1] at N, memread=1 and memaddr=0x40 at N+1, rsp_valid=2'b10 with rsp_rdata=0xDEADBEEF at N+2.
- **Full contention:** NREQ=2, both requesters valid for 6 cycles → grants alternate 0,1,0,1,0,1, with memread or memwrite high every cycle.
- **Mixed traffic:** req 0 writes 0x55 to 0x10 with be=4'b0001, same cycle as req 1 reads → req 0 is granted first, memwrite pulse; then req 1's read, with rsp_valid only for req 1.
- **Lock (ARB_LOCK_EN):** req 0 asserts lock for 3 accesses while req 1 is valid → gnt[0] for 3 consecutive cycles, then gnt[1].
- **Reset mid-read:** reset asserted in cycle N+1 of a read → no rsp_valid in N+2, and rr_ptr = 0.
